// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens (also used by the transmitter
// encoder), alignment FSM state type and the token classifier.
package tmds_pkg;

  // Control tokens as 10-bit words; bit 0 is the first bit on the wire.
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } tmds_align_state_t;

  // Returns {hit, cd[1:0]}; cd is 0 when the word is not a token.
  function automatic logic [2:0] is_ctrl_token(input logic [9:0] w);
    logic [2:0] r;
    case (w)
      TMDS_CTRL_00: r = 3'b100;
      TMDS_CTRL_01: r = 3'b101;
      TMDS_CTRL_10: r = 3'b110;
      TMDS_CTRL_11: r = 3'b111;
      default:      r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational 10b->8b TMDS data decode plus control-token classification.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic [7:0] data,
  output logic       ctrl_hit,
  output logic [1:0] ctrl_cd
);

  logic [7:0] q;

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
  always_comb begin
    q       = word[9] ? ~word[7:0] : word[7:0];
    data    = '0;
    data[0] = q[0];
    for (int i = 1; i < 8; i++)
      data[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    {ctrl_hit, ctrl_cd} = is_ctrl_token(word);
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// Receive-side decoder for one DVI TMDS lane: bit-slip word alignment by
// control-token runs, then 10b->8b decode with a DE flag.
// Optional lock statistics outputs when TMDS_LOCK_STATS_EN is defined.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  raw_word,
  output logic [7:0]  vd,
  output logic [1:0]  cd,
  output logic        de,
  output logic        locked,
  output logic [3:0]  offset
`ifdef TMDS_LOCK_STATS_EN
  ,
  output logic [15:0] lock_loss_cnt,
  output logic [15:0] slip_cnt
`endif
);

  localparam int RUN_W  = (CTRL_RUN > 1) ? $clog2(CTRL_RUN) : 1;
  localparam int TMO_MX = (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
  localparam int TMO_W  = $clog2(TMO_MX);

  tmds_align_state_t state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [3:0]        offset_q, offset_d;
  logic [9:0]        prev_q, prev_d;
  logic [9:0]        align_q, align_d;
  logic [7:0]        vd_q, vd_d;
  logic [1:0]        cd_q, cd_d;
  logic              de_q, de_d;

  logic [19:0]       win_sh;
  logic [7:0]        dec_data;
  logic              dec_hit;
  logic [1:0]        dec_cd;

  // Alignment window: previous word below current, slid right by offset.
  always_comb begin
    prev_d  = raw_word;
    win_sh  = {raw_word, prev_q} >> offset_q;
    align_d = win_sh[9:0];
  end

  // Decode and classify the stage-1 aligned word.
  tmds_word_decode u_dec (
    .word     (align_q),
    .data     (dec_data),
    .ctrl_hit (dec_hit),
    .ctrl_cd  (dec_cd)
  );

  // Alignment FSM: hunt for a token run, slip on timeout, drop on silence.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    tmo_d    = tmo_q;
    offset_d = offset_q;
    case (state_q)
      SEARCH: begin
        tmo_d = tmo_q + 1'b1;
        run_d = dec_hit ? run_q + 1'b1 : '0;
        // Lock has priority over a coincident slip.
        if (dec_hit && run_q == RUN_W'(CTRL_RUN - 1)) begin
          state_d = LOCKED;
          run_d   = '0;
          tmo_d   = '0;
        end else if (tmo_q == TMO_W'(SEARCH_TIMEOUT - 1)) begin
          offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          run_d    = '0;
          tmo_d    = '0;
        end
      end
      LOCKED: begin
        if (dec_hit) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
          state_d = SEARCH;
          run_d   = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Stage-2 outputs: data updates vd, tokens update cd, nothing while unlocked.
  always_comb begin
    vd_d = vd_q;
    cd_d = cd_q;
    de_d = 1'b0;
    if (state_q == LOCKED) begin
      if (dec_hit) begin
        cd_d = dec_cd;
      end else begin
        vd_d = dec_data;
        de_d = 1'b1;
      end
    end
  end

  // State, counters and pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SEARCH;
      run_q    <= '0;
      tmo_q    <= '0;
      offset_q <= '0;
      prev_q   <= '0;
      align_q  <= '0;
      vd_q     <= '0;
      cd_q     <= '0;
      de_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      tmo_q    <= tmo_d;
      offset_q <= offset_d;
      prev_q   <= prev_d;
      align_q  <= align_d;
      vd_q     <= vd_d;
      cd_q     <= cd_d;
      de_q     <= de_d;
    end
  end

  assign vd     = vd_q;
  assign cd     = cd_q;
  assign de     = de_q;
  assign locked = (state_q == LOCKED);
  assign offset = offset_q;

`ifdef TMDS_LOCK_STATS_EN
  logic [15:0] loss_cnt_q, loss_cnt_d;
  logic [15:0] slip_cnt_q, slip_cnt_d;

  // Saturating event counters for lock loss and offset slips.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    slip_cnt_d = slip_cnt_q;
    if (state_q == LOCKED && state_d == SEARCH && loss_cnt_q != 16'hFFFF)
      loss_cnt_d = loss_cnt_q + 16'd1;
    if (offset_d != offset_q && slip_cnt_q != 16'hFFFF)
      slip_cnt_d = slip_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loss_cnt_q <= '0;
      slip_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
  assign slip_cnt      = slip_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: alignment search, decode, lock
// loss, offset wrap and asynchronous reset.
module tb_tmds_channel_decoder;
  import tmds_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] raw_word = '0;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       de;
  logic       locked;
  logic [3:0] offset;
`ifdef TMDS_LOCK_STATS_EN
  logic [15:0] lock_loss_cnt;
  logic [15:0] slip_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cur_k = 0;                       // stream bit offset the bench emits
  logic [9:0] prev_sym = TMDS_CTRL_01;
  int disp = 0;                        // encoder running disparity

  localparam logic [9:0] DATA_00 = 10'b0100000000;

  always #5 clk = ~clk;

  tmds_channel_decoder dut (
    .clk           (clk),
    .reset         (reset),
    .raw_word      (raw_word),
    .vd            (vd),
    .cd            (cd),
    .de            (de),
    .locked        (locked),
    .offset        (offset)
`ifdef TMDS_LOCK_STATS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt),
    .slip_cnt      (slip_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Emit one symbol into a serial stream delayed by cur_k bits, one clock.
  task automatic step(input logic [9:0] s);
    logic [19:0] w;
    w        = {s, prev_sym};
    w        = w >> (10 - cur_k);
    raw_word = w[9:0];
    prev_sym = s;
    @(posedge clk);
    #1;
  endtask

  // Transmitter-side TMDS data encoder.
  task automatic enc(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    int n1, n1q, n0q;
    n1    = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q    = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      disp = disp + (qm[8] ? (n1q - n0q) : (n0q - n1q));
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      q    = {1'b1, qm[8], ~qm[7:0]};
      disp = disp + 2 * int'(qm[8]) + (n0q - n1q);
    end else begin
      q    = {1'b0, qm[8], qm[7:0]};
      disp = disp - 2 * int'(!qm[8]) + (n1q - n0q);
    end
  endtask

  // Feed token-01 stream at offset k right after reset or a slip; the
  // decoder slips once every 2048 cycles and locks 9 cycles after offset k.
  task automatic search_lock(input int k);
    int e, lk;
    cur_k = k;
    e  = 2048 * k;
    lk = (k == 0) ? 10 : e + 9;
    for (int s = 1; s <= lk; s++) begin
      step(TMDS_CTRL_01);
      if (k > 0 && s == e - 1) chk("offset_before_slip", 16'(offset), 16'(k - 1));
      if (s > 0 && s % 2048 == 0) chk("offset_slip", 16'(offset), 16'(s / 2048));
      if (s == lk - 1) begin
        chk("locked_early", 16'(locked), 16'd0);
        chk("de_search", 16'(de), 16'd0);
      end
      if (s == lk) begin
        chk("locked_rise", 16'(locked), 16'd1);
        chk("offset_lock", 16'(offset), 16'(k));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [9:0] sym;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 16'(locked), 16'd0);
    chk("rst_de", 16'(de), 16'd0);
    chk("rst_vd", 16'(vd), 16'd0);
    chk("rst_cd", 16'(cd), 16'd0);
    chk("rst_offset", 16'(offset), 16'd0);
`ifdef TMDS_LOCK_STATS_EN
    chk("rst_loss", lock_loss_cnt, 16'd0);
    chk("rst_slip", slip_cnt, 16'd0);
`endif
    reset = 1'b1;

    // Token stream at offset 3: slips 0->1->2->3 then lock
    search_lock(3);
`ifdef TMDS_LOCK_STATS_EN
    chk("slip_cnt_3", slip_cnt, 16'd3);
`endif
    repeat (64) step(TMDS_CTRL_01);
    chk("tok_cd", 16'(cd), 16'd1);
    chk("tok_de", 16'(de), 16'd0);
    chk("tok_locked", 16'(locked), 16'd1);

    // Data at offset 3, then asynchronous reset mid-data
    repeat (3) step(10'b1011111111);
    chk("off3_de", 16'(de), 16'd1);
    chk("off3_vd", 16'(vd), 16'hFE);
    #2 reset = 1'b0;
    #1;
    chk("arst_locked", 16'(locked), 16'd0);
    chk("arst_de", 16'(de), 16'd0);
    chk("arst_vd", 16'(vd), 16'd0);
    chk("arst_cd", 16'(cd), 16'd0);
    chk("arst_offset", 16'(offset), 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    search_lock(3);

    // Lock at offset 0, directed data words
    do_reset();
    search_lock(0);
    step(10'b0100000000);
    step(10'b1011111111);
    step(10'b1111111111);
    chk("dw0_vd", 16'(vd), 16'h00);
    chk("dw0_de", 16'(de), 16'd1);
    step(TMDS_CTRL_00);
    chk("dw1_vd", 16'(vd), 16'hFE);
    chk("dw1_de", 16'(de), 16'd1);
    step(TMDS_CTRL_00);
    chk("dw2_vd", 16'(vd), 16'h00);
    step(TMDS_CTRL_00);
    chk("dw_tok_de", 16'(de), 16'd0);
    chk("dw_tok_cd", 16'(cd), 16'd0);
    chk("dw_tok_vdhold", 16'(vd), 16'h00);

    // Encoded ramp between blanking tokens
    repeat (3) step(TMDS_CTRL_10);
    chk("blank10_cd", 16'(cd), 16'd2);
    disp = 0;
    for (int j = 0; j < 260; j++) begin
      if (j < 256) enc(8'(j), sym);
      else sym = TMDS_CTRL_00;
      step(sym);
      if (j >= 2 && j < 258) begin
        chk("ramp_vd", 16'(vd), 16'(j - 2));
        chk("ramp_de", 16'(de), 16'd1);
      end
    end
    chk("ramp_blank_de", 16'(de), 16'd0);
    chk("ramp_blank_cd", 16'(cd), 16'd0);

    // Lock loss after 4096 data words without a token
    repeat (2) step(TMDS_CTRL_00);
    for (int n = 1; n <= 4098; n++) begin
      step(DATA_00);
      if (n == 4097) chk("lock_hold", 16'(locked), 16'd1);
      if (n == 4098) begin
        chk("lock_drop", 16'(locked), 16'd0);
        chk("lock_drop_off", 16'(offset), 16'd0);
`ifdef TMDS_LOCK_STATS_EN
        chk("loss_cnt", lock_loss_cnt, 16'd1);
        chk("loss_slip", slip_cnt, 16'd0);
`endif
      end
    end
    step(DATA_00);
    chk("drop_de", 16'(de), 16'd0);

    // Offset wrap 9 -> 0, then search up to 9 and lock
    do_reset();
    cur_k = 0;
    for (int s = 1; s <= 20480; s++) begin
      step(DATA_00);
      if (s == 18432) begin
        chk("wrap_off9", 16'(offset), 16'd9);
`ifdef TMDS_LOCK_STATS_EN
        chk("wrap_slip9", slip_cnt, 16'd9);
`endif
      end
      if (s == 20479) chk("wrap_pre", 16'(offset), 16'd9);
      if (s == 20480) begin
        chk("wrap_off0", 16'(offset), 16'd0);
        chk("wrap_unlocked", 16'(locked), 16'd0);
`ifdef TMDS_LOCK_STATS_EN
        chk("wrap_slip10", slip_cnt, 16'd10);
`endif
      end
    end
    search_lock(9);
`ifdef TMDS_LOCK_STATS_EN
    chk("slip_cnt_19", slip_cnt, 16'd19);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
